// File: rtl/opl_seq_pkg.sv
// Shared types and constants for the OPL3 register write sequencer.
package opl_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_WE,
        ADDR_GAP,
        DATA_WE,
        DATA_GAP,
        STAT_ADDR,
        STAT_CAP
    } opl_seq_state_t;

    localparam logic OPL_ADDR_INDEX = 1'b0;
    localparam logic OPL_ADDR_DATA  = 1'b1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opl_cmd_fifo.sv
// First-word fall-through command FIFO with occupancy output; a push is refused while full.
module opl_cmd_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/opl_write_sequencer.sv
// Replays queued OPL3 register writes as index/data bus pairs with settle delays, plus status reads.
// Optional OPLSEQ_SKIP_ADDR_EN: skip the index phase when the popped index was the last one written.
module opl_write_sequencer
    import opl_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WE_CYCLES  = 2,
    parameter int unsigned ADDR_WAIT  = 12,
    parameter int unsigned DATA_WAIT  = 84
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [8:0]                    cmd_index,
    input  logic [7:0]                    cmd_data,
    input  logic                          status_req,
    output logic                          status_valid,
    output logic [7:0]                    status_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    opl_addr,
    output logic [7:0]                    opl_din,
    output logic                          opl_we,
    input  logic [7:0]                    opl_dout
);

    localparam int unsigned CW = $clog2(max3(WE_CYCLES, ADDR_WAIT, DATA_WAIT) + 1);
    localparam logic [CW-1:0] WE_LD = CW'(WE_CYCLES);
    localparam logic [CW-1:0] AW_LD = CW'(ADDR_WAIT);
    localparam logic [CW-1:0] DW_LD = CW'(DATA_WAIT);

    opl_seq_state_t state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [1:0]     addr_nx;
    logic [7:0]     din_nx;
    logic           we_nx;
    logic           cur_hi, cur_hi_nx;
    logic [7:0]     cur_data, cur_data_nx;
    logic           status_pending;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [16:0]    fifo_head;
    logic [8:0]     head_idx;
    logic [7:0]     head_data;
    logic           cnt_done;

`ifdef OPLSEQ_SKIP_ADDR_EN
    logic [8:0]     last_idx, last_idx_nx;
    logic           last_valid, last_valid_nx;
`endif

    opl_cmd_fifo #(
        .WIDTH(17),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_valid),
        .push_data({cmd_index, cmd_data}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

    assign head_idx  = fifo_head[16:8];
    assign head_data = fifo_head[7:0];
    assign cmd_ready = !fifo_full;
    assign busy      = (state != IDLE) || !fifo_empty || status_pending;
    assign cnt_done  = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            opl_addr       <= '0;
            opl_din        <= '0;
            opl_we         <= 1'b0;
            cur_hi         <= 1'b0;
            cur_data       <= '0;
            status_pending <= 1'b0;
            status_valid   <= 1'b0;
            status_data    <= '0;
`ifdef OPLSEQ_SKIP_ADDR_EN
            last_idx       <= '0;
            last_valid     <= 1'b0;
`endif
        end else begin
            state          <= state_nx;
            cnt            <= cnt_nx;
            opl_addr       <= addr_nx;
            opl_din        <= din_nx;
            opl_we         <= we_nx;
            cur_hi         <= cur_hi_nx;
            cur_data       <= cur_data_nx;
            // A request landing on the capture cycle re-arms the pending flag
            status_pending <= (status_pending && (state != STAT_CAP)) || status_req;
            status_valid   <= (state == STAT_CAP);
            if (state == STAT_CAP) begin
                status_data <= opl_dout;
            end
`ifdef OPLSEQ_SKIP_ADDR_EN
            last_idx       <= last_idx_nx;
            last_valid     <= last_valid_nx;
`endif
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        addr_nx     = opl_addr;
        din_nx      = opl_din;
        we_nx       = opl_we;
        cur_hi_nx   = cur_hi;
        cur_data_nx = cur_data;
        fifo_pop    = 1'b0;
`ifdef OPLSEQ_SKIP_ADDR_EN
        last_idx_nx   = last_idx;
        last_valid_nx = last_valid;
`endif
        case (state)
            IDLE: begin
                if (status_pending) begin
                    state_nx = STAT_ADDR;
                    cnt_nx   = CW'(1);
                    addr_nx  = '0;
                    we_nx    = 1'b0;
`ifdef OPLSEQ_SKIP_ADDR_EN
                    last_valid_nx = 1'b0;
`endif
                end else if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cur_hi_nx   = head_idx[8];
                    cur_data_nx = head_data;
                    cnt_nx      = WE_LD;
                    we_nx       = 1'b1;
`ifdef OPLSEQ_SKIP_ADDR_EN
                    if (last_valid && (head_idx == last_idx)) begin
                        state_nx = DATA_WE;
                        addr_nx  = {head_idx[8], OPL_ADDR_DATA};
                        din_nx   = head_data;
                    end else begin
                        state_nx      = ADDR_WE;
                        addr_nx       = {head_idx[8], OPL_ADDR_INDEX};
                        din_nx        = head_idx[7:0];
                        last_idx_nx   = head_idx;
                        last_valid_nx = 1'b1;
                    end
`else
                    state_nx = ADDR_WE;
                    addr_nx  = {head_idx[8], OPL_ADDR_INDEX};
                    din_nx   = head_idx[7:0];
`endif
                end
            end
            ADDR_WE: begin
                if (cnt_done) begin
                    state_nx = ADDR_GAP;
                    cnt_nx   = AW_LD;
                    we_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ADDR_GAP: begin
                if (cnt_done) begin
                    state_nx = DATA_WE;
                    cnt_nx   = WE_LD;
                    addr_nx  = {cur_hi, OPL_ADDR_DATA};
                    din_nx   = cur_data;
                    we_nx    = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA_WE: begin
                if (cnt_done) begin
                    state_nx = DATA_GAP;
                    cnt_nx   = DW_LD;
                    we_nx    = 1'b0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            DATA_GAP: begin
                if (cnt_done) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            STAT_ADDR: state_nx = STAT_CAP;
            STAT_CAP:  state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_opl_write_sequencer.sv
// Scoreboard bench for opl_write_sequencer: stimulus feeds a command/status model, a monitor checks the bus.
module tb_opl_write_sequencer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WEC   = 2;
    localparam int unsigned AWAIT = 12;
    localparam int unsigned DWAIT = 84;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [8:0] cmd_index = '0;
    logic [7:0] cmd_data = '0;
    logic       status_req = 1'b0;
    logic       status_valid;
    logic [7:0] status_data;
    logic       busy;
    logic [4:0] fifo_level;
    logic [1:0] opl_addr;
    logic [7:0] opl_din;
    logic       opl_we;
    logic [7:0] opl_dout;
    logic [7:0] stat_val = 8'h00;

    assign opl_dout = (opl_addr == 2'd0) ? stat_val : 8'h5A;

    always #5 clk = ~clk;

    opl_write_sequencer #(
        .FIFO_DEPTH(DEPTH),
        .WE_CYCLES (WEC),
        .ADDR_WAIT (AWAIT),
        .DATA_WAIT (DWAIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_data    (cmd_data),
        .status_req  (status_req),
        .status_valid(status_valid),
        .status_data (status_data),
        .busy        (busy),
        .fifo_level  (fifo_level),
        .opl_addr    (opl_addr),
        .opl_din     (opl_din),
        .opl_we      (opl_we),
        .opl_dout    (opl_dout)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: accepted commands, expected bus writes {addr,din}, expected status reads
    logic [16:0] cmd_q[$];
    logic [9:0]  exp_w[$];
    logic [7:0]  sq_data[$];
    int          sq_writes[$];
`ifdef OPLSEQ_SKIP_ADDR_EN
    logic [8:0]  m_last = '0;
    bit          m_last_v = 1'b0;
`endif

    int         writes_seen = 0;
    int         data_writes = 0;
    bit         prev_we = 1'b0;
    bit         first = 1'b1;
    bit         last_index = 1'b0;
    bit         stab_err = 1'b0;
    int         high_len = 0;
    int         low_len = 0;
    logic [1:0] cap_addr = '0;
    logic [7:0] cap_din = '0;
    logic [9:0] mon_e;
    logic [7:0] mon_d;
    int         mon_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expand_next();
        logic [16:0] c;
        logic [8:0]  idx;
        c   = cmd_q.pop_front();
        idx = c[16:8];
`ifdef OPLSEQ_SKIP_ADDR_EN
        if (!(m_last_v && (m_last == idx))) exp_w.push_back({idx[8], 1'b0, idx[7:0]});
        m_last   = idx;
        m_last_v = 1'b1;
`else
        exp_w.push_back({idx[8], 1'b0, idx[7:0]});
`endif
        exp_w.push_back({idx[8], 1'b1, c[7:0]});
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_we = 1'b0;
            first   = 1'b1;
        end else begin
            if (status_valid) begin
                if (sq_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL status_unexpected: actual data=0x%0h required=no pulse", status_data);
                end else begin
                    mon_d = sq_data.pop_front();
                    mon_w = sq_writes.pop_front();
                    chk("status_data", status_data, mon_d);
                    chk("status_order", writes_seen, mon_w);
                end
`ifdef OPLSEQ_SKIP_ADDR_EN
                m_last_v = 1'b0;
`endif
            end
            if (opl_we && !prev_we) begin
                if (exp_w.size() == 0 && cmd_q.size() != 0) expand_next();
                if (exp_w.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL bus_unexpected: actual addr=%0d din=0x%0h required=no write", opl_addr, opl_din);
                end else begin
                    mon_e = exp_w.pop_front();
                    chk("bus_write", {opl_addr, opl_din}, mon_e);
                end
                if (!first) begin
                    if (last_index) begin
                        chk("addr_gap", low_len, AWAIT);
                    end else begin
                        tests++;
                        if (low_len < DWAIT) begin
                            fails++;
                            $display("FAIL data_gap: actual=%0d required>=%0d", low_len, DWAIT);
                        end
                    end
                end
                last_index = !opl_addr[0];
                cap_addr   = opl_addr;
                cap_din    = opl_din;
                high_len   = 1;
                stab_err   = 1'b0;
                writes_seen++;
                if (opl_addr[0]) data_writes++;
            end else if (opl_we) begin
                high_len++;
                if (opl_addr !== cap_addr || opl_din !== cap_din) stab_err = 1'b1;
            end else if (prev_we) begin
                chk("we_width", high_len, WEC);
                chk("we_stable", stab_err, 0);
                low_len = 1;
                first   = 1'b0;
            end else begin
                low_len++;
            end
            prev_we = opl_we;
        end
    end

    task automatic push(input logic [8:0] idx, input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_data  = d;
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            cmd_q.push_back({idx, d});
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || cmd_q.size() != 0 || exp_w.size() != 0) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(name, cmd_q.size() + exp_w.size() + sq_data.size() + int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_q.delete();
        exp_w.delete();
        sq_data.delete();
        sq_writes.delete();
`ifdef OPLSEQ_SKIP_ADDR_EN
        m_last_v = 1'b0;
`endif
        @(negedge clk);
        chk("rst_we", opl_we, 0);
        chk("rst_addr", opl_addr, 0);
        chk("rst_din", opl_din, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_svalid", status_valid, 0);
        chk("rst_sdata", status_data, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic status_pulse(input int hold);
        stat_val   = 8'($urandom);
        status_req = 1'b1;
        sq_data.push_back(stat_val);
        sq_writes.push_back(writes_seen);
        repeat (hold) @(negedge clk);
        status_req = 1'b0;
    endtask

    initial begin
        int n;
        int w0;
        int d0;
        logic [8:0] idx;

        @(negedge clk);
        do_reset();

        push(9'h0B0, 8'h31);
        n = 0;
        while (!opl_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("first_latency", n, 1);
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("busy_duration", n, 2 * WEC + AWAIT + DWAIT);
        drain("t1_drain");

        push(9'h105, 8'h01);
        drain("t2_drain");

        for (int i = 0; i < 17; i++) push(9'($urandom_range(0, 511)), 8'(i));
        chk("full_ready", cmd_ready, 0);
        chk("full_level", fifo_level, DEPTH);
        drain("t3_drain");

        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) push(9'($urandom_range(0, 511)), 8'($urandom));
            d0 = data_writes;
            n  = 0;
            while (data_writes == d0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("t4_wait_data", (data_writes != d0) ? 1 : 0, 1);
            repeat ($urandom_range(3, 60)) @(negedge clk);
            status_pulse((k == 1) ? 2 : 1);
            drain("t4_drain");
        end

        for (int i = 0; i < 40; i++) begin
            idx = 9'($urandom_range(0, 3)) | 9'h040;
            if ($urandom_range(0, 1) == 1) idx[8] = 1'b1;
            push(idx, 8'($urandom));
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        drain("rand_drain");

        status_pulse(1);
        drain("t6_status");
        w0 = writes_seen;
        push(9'h040, 8'h10);
        push(9'h040, 8'h20);
        drain("t6_drain");
`ifdef OPLSEQ_SKIP_ADDR_EN
        chk("t6_write_count", writes_seen - w0, 3);
`else
        chk("t6_write_count", writes_seen - w0, 4);
`endif

        for (int i = 0; i < 6; i++) push(9'($urandom_range(0, 511)), 8'($urandom));
        n = 0;
        while (!opl_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (opl_we && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_in_gap", (n < 100) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        do_reset();
        w0 = writes_seen;
        repeat (300) @(negedge clk);
        chk("t5_no_writes", writes_seen - w0, 0);
        chk("t5_idle", busy, 0);

        chk("final_queues", cmd_q.size() + exp_w.size() + sq_data.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
